// File: rtl/cache_ctrl.sv
// Set-associative write-back, write-allocate cache controller with one word per line.
// A single memory port serves refills and writebacks; hit/miss counters saturate.
module cache_ctrl #(
    parameter int unsigned WAY  = 4,
    parameter int unsigned SETS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    localparam int unsigned IDX_W = (SETS > 1) ? $clog2(SETS) : 1;
    localparam int unsigned WAY_W = (WAY > 1) ? $clog2(WAY) : 1;
    localparam int unsigned TAG_W = 32 - 2 - IDX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WRITEBACK,
        S_REFILL,
        S_RESPOND
    } state_t;

    state_t              state_q;
    logic                we_q;
    logic [31:2]         addr_q;
    logic [31:0]         wdata_q;
    logic [WAY_W-1:0]    way_q;

    logic [WAY-1:0]      valid_q [SETS];
    logic [WAY-1:0]      dirty_q [SETS];
    logic [WAY-1:0]      mru_q   [SETS];
    logic [TAG_W-1:0]    tag_q   [SETS][WAY];
    logic [31:0]         data_q  [SETS][WAY];

    logic [IDX_W-1:0]    idx_c;
    logic [TAG_W-1:0]    tag_c;
    logic                hit_c;
    logic [WAY_W-1:0]    hit_way_c;
    logic                inv_found_c;
    logic [WAY_W-1:0]    inv_way_c;
    logic                mru0_found_c;
    logic [WAY_W-1:0]    mru0_way_c;
    logic [WAY_W-1:0]    victim_c;
    logic                fill_c;
    logic                unused_addr_lsb_c;

    assign idx_c             = addr_q[2 +: IDX_W];
    assign tag_c             = addr_q[31 -: TAG_W];
    assign fill_c            = (state_q == S_REFILL) && mem_req && mem_ack;
    assign unused_addr_lsb_c = ^cpu_addr[1:0];

    // Set the accessed way's mru bit; if that would saturate the set, keep only it.
    function automatic logic [WAY-1:0] mru_touch(input logic [WAY-1:0] cur,
                                                 input logic [WAY_W-1:0] w);
        logic [WAY-1:0] onehot;
        onehot    = '0;
        onehot[w] = 1'b1;
        return (&(cur | onehot)) ? onehot : (cur | onehot);
    endfunction

    // Tag compare and victim choice for the latched address.
    always_comb begin
        hit_c        = 1'b0;
        hit_way_c    = '0;
        inv_found_c  = 1'b0;
        inv_way_c    = '0;
        mru0_found_c = 1'b0;
        mru0_way_c   = '0;
        for (int w = 0; w < WAY; w++) begin
            if (!hit_c && valid_q[idx_c][w] && (tag_q[idx_c][w] == tag_c)) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_W'(w);
            end
            if (!inv_found_c && !valid_q[idx_c][w]) begin
                inv_found_c = 1'b1;
                inv_way_c   = WAY_W'(w);
            end
            if (!mru0_found_c && !mru_q[idx_c][w]) begin
                mru0_found_c = 1'b1;
                mru0_way_c   = WAY_W'(w);
            end
        end
        victim_c = inv_found_c ? inv_way_c : mru0_way_c;
    end

    // Data and tag arrays carry no reset; a cleared valid bit hides their contents.
    always_ff @(posedge clk) begin
        if (fill_c) begin
            tag_q[idx_c][way_q]  <= tag_c;
            data_q[idx_c][way_q] <= we_q ? wdata_q : mem_rdata;
        end else if ((state_q == S_LOOKUP) && hit_c && we_q) begin
            data_q[idx_c][hit_way_c] <= wdata_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            way_q      <= '0;
            valid_q    <= '{default: '0};
            dirty_q    <= '{default: '0};
            mru_q      <= '{default: '0};
            cpu_rdata  <= '0;
            cpu_ready  <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            cpu_ready <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cpu_req) begin
                        we_q    <= cpu_we;
                        addr_q  <= cpu_addr[31:2];
                        wdata_q <= cpu_wdata;
                        state_q <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit_c) begin
                        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
                        way_q     <= hit_way_c;
                        cpu_ready <= 1'b1;
                        cpu_rdata <= we_q ? wdata_q : data_q[idx_c][hit_way_c];
                        if (we_q) dirty_q[idx_c][hit_way_c] <= 1'b1;
                        mru_q[idx_c] <= mru_touch(mru_q[idx_c], hit_way_c);
                        state_q   <= S_RESPOND;
                    end else begin
                        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
                        way_q   <= victim_c;
                        mem_req <= 1'b1;
                        if (valid_q[idx_c][victim_c] && dirty_q[idx_c][victim_c]) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= {tag_q[idx_c][victim_c], idx_c, 2'b00};
                            mem_wdata <= data_q[idx_c][victim_c];
                            state_q   <= S_WRITEBACK;
                        end else begin
                            mem_we   <= 1'b0;
                            mem_addr <= {addr_q, 2'b00};
                            state_q  <= S_REFILL;
                        end
                    end
                end
                S_WRITEBACK: begin
                    // Request drops for a cycle before the refill is issued.
                    if (mem_req && mem_ack) begin
                        mem_req               <= 1'b0;
                        dirty_q[idx_c][way_q] <= 1'b0;
                        state_q               <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {addr_q, 2'b00};
                    end else if (mem_ack) begin
                        mem_req               <= 1'b0;
                        valid_q[idx_c][way_q] <= 1'b1;
                        dirty_q[idx_c][way_q] <= we_q;
                        mru_q[idx_c]          <= mru_touch(mru_q[idx_c], way_q);
                        cpu_ready             <= 1'b1;
                        cpu_rdata             <= we_q ? wdata_q : mem_rdata;
                        state_q               <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: scoreboard queues for CPU read data and memory
// transactions, with a latency-3 memory responder.
module tb_cache_ctrl;

    localparam int ACK_DLY = 3;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_op_t;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int errors = 0;
    int checks = 0;
    int n_rd   = 0;
    int n_wb   = 0;
    bit mem_en = 1'b1;

    logic [31:0] exp_rd_q [$];
    mem_op_t     exp_mem_q [$];
    logic [31:0] mem_model [logic [31:0]];

    cache_ctrl #(.WAY(4), .SETS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic exp_mem(input logic we, input logic [31:0] a, input logic [31:0] wd);
        exp_mem_q.push_back('{we: we, addr: a, wdata: wd});
    endtask

    // One CPU access; lat counts falling edges from request to cpu_ready.
    task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp, output int lat);
        exp_rd_q.push_back(exp);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                cpu_req = 1'b0; cpu_we = ~we; cpu_addr = $urandom; cpu_wdata = $urandom;
            end
        end while (cpu_ready !== 1'b1 && lat < 100);
        check("cpu_ready_seen", cpu_ready, 1'b1);
        @(negedge clk);
        check("cpu_ready_pulse", cpu_ready, 1'b0);
    endtask

    // Read-data scoreboard.
    always @(negedge clk) begin
        if (cpu_ready === 1'b1) begin
            if (exp_rd_q.size() == 0) check("rdata_unexpected", 32'd1, 32'd0);
            else check("cpu_rdata", cpu_rdata, exp_rd_q.pop_front());
        end
    end

    // Memory responder: checks each request against the expected-op queue.
    initial begin
        mem_op_t cur;
        mem_op_t e;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_en && mem_req === 1'b1) begin
                cur = '{we: mem_we, addr: mem_addr, wdata: mem_wdata};
                if (exp_mem_q.size() == 0) begin
                    check("mem_unexpected", cur.addr, 32'hFFFF_FFFF);
                end else begin
                    e = exp_mem_q.pop_front();
                    check("mem_we", cur.we, e.we);
                    check("mem_addr", cur.addr, e.addr);
                    if (e.we) check("mem_wdata", cur.wdata, e.wdata);
                end
                repeat (ACK_DLY - 1) begin
                    @(negedge clk);
                    check("mem_hold_req", mem_req, 1'b1);
                    check("mem_hold_addr", mem_addr, cur.addr);
                end
                if (cur.we) begin
                    mem_model[cur.addr] = cur.wdata;
                    n_wb++;
                end else begin
                    mem_rdata = mem_read(cur.addr);
                    n_rd++;
                end
                mem_ack = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int cnt;
        reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_model[32'h10] = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        check("rst_cpu_ready", cpu_ready, 1'b0);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_hit", hit_count, 16'h0);
        check("rst_miss", miss_count, 16'h0);
        reset = 1'b1;

        // Cold read miss then hit on the same line.
        exp_mem(1'b0, 32'h10, 32'h0);
        access(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, lat);
        check("cold_miss_count", miss_count, 16'd1);
        check("cold_hit_count", hit_count, 16'd0);
        access(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, lat);
        check("hit_latency", lat, 2);
        check("hit_count_1", hit_count, 16'd1);
        check("hit_no_mem", n_rd, 1);

        // Fill set 0 with dirty lines, then force an eviction with writeback.
        access(1'b1, 32'h10, 32'h1111_1111, 32'h1111_1111, lat);
        check("write_hit_latency", lat, 2);
        exp_mem(1'b0, 32'h20, 32'h0);
        access(1'b1, 32'h20, 32'h1111_1111, 32'h1111_1111, lat);
        exp_mem(1'b0, 32'h30, 32'h0);
        access(1'b1, 32'h30, 32'h1111_1111, 32'h1111_1111, lat);
        exp_mem(1'b0, 32'h40, 32'h0);
        access(1'b1, 32'h40, 32'h1111_1111, 32'h1111_1111, lat);
        exp_mem(1'b1, 32'h10, 32'h1111_1111);
        exp_mem(1'b0, 32'h50, 32'h0);
        access(1'b0, 32'h50, 32'h0, pat(32'h50), lat);
        check("set0_refills", n_rd, 5);
        check("set0_writebacks", n_wb, 1);
        check("set0_miss", miss_count, 16'd5);
        check("set0_hit", hit_count, 16'd2);

        // Set 1: after touching way0, the next miss must evict way1.
        for (int i = 0; i < 4; i++) begin
            exp_mem(1'b0, 32'h04 + 32'(i) * 32'h10, 32'h0);
            access(1'b0, 32'h04 + 32'(i) * 32'h10, 32'h0, pat(32'h04 + 32'(i) * 32'h10), lat);
        end
        access(1'b0, 32'h04, 32'h0, pat(32'h04), lat);
        exp_mem(1'b0, 32'h44, 32'h0);
        access(1'b0, 32'h44, 32'h0, pat(32'h44), lat);
        access(1'b0, 32'h04, 32'h0, pat(32'h04), lat);
        access(1'b0, 32'h24, 32'h0, pat(32'h24), lat);
        access(1'b0, 32'h34, 32'h0, pat(32'h34), lat);
        exp_mem(1'b0, 32'h14, 32'h0);
        access(1'b0, 32'h14, 32'h0, pat(32'h14), lat);
        check("set1_hit", hit_count, 16'd6);
        check("set1_miss", miss_count, 16'd11);
        check("set1_refills", n_rd, 11);

        // Hit counter saturation.
        @(negedge clk);
        force dut.hit_count = 16'hFFFE;
        #1 release dut.hit_count;
        check("sat_preset", hit_count, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            access(1'b0, 32'h24, 32'h0, pat(32'h24), lat);
            check("sat_hit_count", hit_count, 16'hFFFF);
        end

        // Reset in the middle of a refill abandons it.
        mem_en = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h08;
        @(negedge clk);
        cpu_req = 1'b0;
        cnt = 0;
        while (mem_req !== 1'b1 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("abort_req_seen", mem_req, 1'b1);
        check("abort_req_addr", mem_addr, 32'h08);
        check("abort_req_we", mem_we, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("abort_mem_req", mem_req, 1'b0);
        check("abort_mem_addr", mem_addr, 32'h0);
        check("abort_miss", miss_count, 16'h0);
        check("abort_hit", hit_count, 16'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1 mem_ack = 1'b1;
        @(posedge clk);
        #1 mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("stale_ack_req", mem_req, 1'b0);
        check("stale_ack_ready", cpu_ready, 1'b0);
        mem_en = 1'b1;
        exp_mem(1'b0, 32'h08, 32'h0);
        access(1'b0, 32'h08, 32'h0, pat(32'h08), lat);
        check("post_rst_miss", miss_count, 16'd1);
        exp_mem(1'b0, 32'h10, 32'h0);
        access(1'b0, 32'h10, 32'h0, 32'h1111_1111, lat);
        check("post_rst_miss2", miss_count, 16'd2);
        check("post_rst_hit", hit_count, 16'd0);
        check("total_refills", n_rd, 13);

        repeat (2) @(negedge clk);
        check("rd_queue_empty", exp_rd_q.size(), 0);
        check("mem_queue_empty", exp_mem_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
